// File: rtl/io_pkg.sv
// Shared I/O word and input FIFO sizing, common to the Datapath and its input port.
package io_pkg;
  localparam int unsigned IO_WORD_W     = 16;
  localparam int unsigned IN_FIFO_DEPTH = 8;
endpackage

// File: rtl/in_fifo_mem.sv
// Input FIFO storage: synchronous write, asynchronous read, no reset.
module in_fifo_mem #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/in_port_fifo.sv
// First-word-fall-through input port FIFO feeding the Datapath in_data port.
// Define IN_FIFO_STICKY_ERR_EN to make drop_err sticky until reset (default: one-cycle pulse).
module in_port_fifo
  import io_pkg::*;
#(
  parameter int unsigned WIDTH = IO_WORD_W,
  parameter int unsigned DEPTH = IN_FIFO_DEPTH
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         in_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] head_word;
  logic             do_wr, do_rd, drop;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // A read while full frees the slot this write needs, so the write is only dropped when no read accompanies it.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || rd_en);
  assign drop  = wr_en && full && !rd_en;

  in_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .CLK   (CLK),
    .we    (do_wr),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (head_word)
  );

  assign in_data = empty ? '0 : head_word;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (do_rd && !do_wr) count <= count - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      drop_err <= 1'b0;
    end else begin
`ifdef IN_FIFO_STICKY_ERR_EN
      drop_err <= drop_err | drop;
`else
      drop_err <= drop;
`endif
    end
  end

endmodule

// File: tb/tb_in_port_fifo.sv
// Self-checking bench for in_port_fifo: directed scenarios plus randomized traffic against a queue model.
module tb_in_port_fifo;
  import io_pkg::*;

  localparam int W  = IO_WORD_W;
  localparam int D  = IN_FIFO_DEPTH;
  localparam int CW = $clog2(D) + 1;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic [W-1:0]  in_data;
  logic          empty, full, drop_err;
  logic [CW-1:0] count;

  in_port_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK      (CLK),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .in_data  (in_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .drop_err (drop_err)
  );

  always #5 CLK = ~CLK;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] q[$];
  logic         exp_err = 1'b0;
  logic [W-1:0] last_pop = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".count"}, 32'(count), 32'(q.size()));
    check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, ".full"},  32'(full),  32'(q.size() == D));
    check({tag, ".data"},  32'(in_data), (q.size() == 0) ? 32'd0 : 32'(q[0]));
    check({tag, ".err"},   32'(drop_err), 32'(exp_err));
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input string tag, input logic wr, input logic [W-1:0] d, input logic rd);
    bit was_empty, was_full, rd_ok, wr_ok, drop;
    wr_en = wr; wr_data = d; rd_en = rd;
    was_empty = (q.size() == 0);
    was_full  = (q.size() == D);
    rd_ok = rd && !was_empty;
    wr_ok = wr && (!was_full || rd);
    drop  = wr && was_full && !rd;
    if (rd_ok) last_pop = in_data;
    @(posedge CLK);
    #1;
    if (rd_ok) void'(q.pop_front());
    if (wr_ok) q.push_back(d);
`ifdef IN_FIFO_STICKY_ERR_EN
    exp_err = exp_err | drop;
`else
    exp_err = drop;
`endif
    wr_en = 1'b0; rd_en = 1'b0;
    check_outputs(tag);
    check({tag, ".bound"}, 32'(count <= CW'(D)), 32'd1);
  endtask

  // Reset is raised between edges; outputs must clear with no clock edge.
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    q.delete();
    exp_err = 1'b0;
    check_outputs(tag);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #12;
    check_outputs("reset");
    reset = 1'b0;

    step("wr0906", 1'b1, 16'h0906, 1'b0);
    check("wr0906.val", 32'(in_data), 32'h0906);
    step("rd0906", 1'b0, '0, 1'b1);

    for (int i = 1; i <= 8; i++) step("fill", 1'b1, W'(i), 1'b0);
    check("fill.full", 32'(full), 32'd1);
    step("drop", 1'b1, 16'h0009, 1'b0);
    check("drop.err", 32'(drop_err), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      step("drain", 1'b0, '0, 1'b1);
      check("drain.order", 32'(last_pop), 32'(i));
    end

    for (int i = 1; i <= 8; i++) step("fill2", 1'b1, W'(16'h0010 + i), 1'b0);
    step("fullwr", 1'b1, 16'h00AA, 1'b1);
    check("fullwr.count", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) step("drain2", 1'b0, '0, 1'b1);
    check("drain2.last", 32'(last_pop), 32'h00AA);

    step("emptywr", 1'b1, 16'h1234, 1'b1);
    check("emptywr.count", 32'(count), 32'd1);
    check("emptywr.data", 32'(in_data), 32'h1234);
    step("emptywr.pop", 1'b0, '0, 1'b1);

    for (int i = 0; i < 20; i++)
      step("wrap", 1'b1, W'(16'h0100 + i), (i % 2 == 1) || (q.size() >= 6));
    while (q.size() != 0) step("wrapdrain", 1'b0, '0, 1'b1);

    for (int i = 0; i < 5; i++) step("pre5", 1'b1, W'(16'h0200 + i), 1'b0);
    check("pre5.count", 32'(count), 32'd5);
    do_reset("midreset");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(63) == 0) do_reset("rndreset");
      else step("rnd", ($urandom_range(99) < 55), W'($urandom), ($urandom_range(99) < 45));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
